// File: rtl/ram_port_ctrl_if.sv
// ram_port_ctrl_if: client-side request/response bundle for ram_port_ctrl.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid and ready are both 1. While valid is 1 and ready is 0, the
// source holds valid and its payload stable. Ready may depend on state only,
// never combinationally on the same stream's valid.
//
// Signals:
//   i_req_valid / o_req_ready  request handshake
//   i_req_we                   1 = write, 0 = read
//   i_req_addr                 word address (AW bits)
//   i_req_wdata                write data (WIDTH bits)
//   o_rsp_valid / i_rsp_ready  read-response handshake
//   o_rsp_data                 read-response data (WIDTH bits)
//
// Modports:
//   slave  - the controller side (ram_port_ctrl)
//   master - the client side
interface ram_port_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic             i_req_we;
  logic [AW-1:0]    i_req_addr;
  logic [WIDTH-1:0] i_req_wdata;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [WIDTH-1:0] o_rsp_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data
  );
endinterface

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: initiator-side controller for a single-port RAM with a
// 1-cycle read latency. Client requests are forwarded combinationally to the
// RAM on acceptance; returning read data is buffered in a small in-order
// first-word-fall-through FIFO and offered on the response stream.
//
// A registered request-ready implements credit flow control: a request is
// only accepted if every read already in flight or buffered, plus one more,
// fits in the response FIFO, so read data can never be dropped.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   bus (slave)       client request/response streams (see ram_port_ctrl_if)
//   o_ram_addr        RAM shared address
//   o_ram_wr_dv       RAM write strobe
//   o_ram_wr_data     RAM write data
//   o_ram_rd_en       RAM read enable
//   i_ram_rd_dv       RAM read data valid (one cycle after o_ram_rd_en)
//   i_ram_rd_data     RAM read data
//   o_err             sticky: read data arrived with no read outstanding
module ram_port_ctrl #(
  parameter int  WIDTH     = 16,
  parameter int  DEPTH     = 256,
  parameter int  RSP_DEPTH = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ram_port_ctrl_if.slave   bus,
  output logic [AW-1:0]    o_ram_addr,
  output logic             o_ram_wr_dv,
  output logic [WIDTH-1:0] o_ram_wr_data,
  output logic             o_ram_rd_en,
  input  logic             i_ram_rd_dv,
  input  logic [WIDTH-1:0] i_ram_rd_data,
  output logic             o_err
);

  // Count must hold 0..RSP_DEPTH; pointers index 0..RSP_DEPTH-1.
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int SW = CW + 1;

  logic [WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             req_ready_q, req_ready_d;
  logic             err_q;

  logic accept;
  logic push;
  logic pop;
  logic spurious;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    accept      = bus.i_req_valid & req_ready_q;

    o_ram_addr    = bus.i_req_addr;
    o_ram_wr_data = bus.i_req_wdata;
    o_ram_wr_dv   = accept & bus.i_req_we;
    o_ram_rd_en   = accept & ~bus.i_req_we;

    // Data only counts as a response if a read was issued last cycle;
    // anything else is a protocol error and is dropped.
    push     = i_ram_rd_dv & inflight_q;
    spurious = i_ram_rd_dv & ~inflight_q;
    pop      = (count_q != '0) & bus.i_rsp_ready;

    inflight_d = accept & ~bus.i_req_we;
    count_d    = count_q + CW'(push) - CW'(pop);

    // Next-cycle ready reserves room for what will be buffered plus what
    // will still be in flight; it depends only on next-state values.
    req_ready_d = ({1'b0, count_d} + SW'(inflight_d)) < SW'(RSP_DEPTH);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      req_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      req_ready_q <= req_ready_d;
      if (spurious) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_ram_rd_data;
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = (count_q != '0);
  assign bus.o_rsp_data  = mem[rd_ptr_q];
  assign o_err           = err_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed bench for ram_port_ctrl (RSP_DEPTH=2) with a
// behavioural 1-cycle-latency RAM and an expected-response queue.
module tb_ram_port_ctrl;
  localparam int WIDTH = 16;
  localparam int AW    = 8;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  // ---------------- DUT ----------------
  ram_port_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  logic [AW-1:0]    ram_addr;
  logic             ram_wr_dv;
  logic [WIDTH-1:0] ram_wr_data;
  logic             ram_rd_en;
  logic             ram_rd_dv;
  logic [WIDTH-1:0] ram_rd_data;
  logic             err;

  logic             model_dv = 1'b0;
  logic [WIDTH-1:0] model_data = '0;
  logic             inject_dv;
  logic [WIDTH-1:0] ram_mem [256];

  assign ram_rd_dv   = model_dv | inject_dv;
  assign ram_rd_data = inject_dv ? 16'hDEAD : model_data;

  ram_port_ctrl #(.WIDTH(WIDTH), .DEPTH(256), .RSP_DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .bus           (bus),
    .o_ram_addr    (ram_addr),
    .o_ram_wr_dv   (ram_wr_dv),
    .o_ram_wr_data (ram_wr_data),
    .o_ram_rd_en   (ram_rd_en),
    .i_ram_rd_dv   (ram_rd_dv),
    .i_ram_rd_data (ram_rd_data),
    .o_err         (err)
  );

  // Behavioural single-port RAM, read data one cycle after rd_en.
  always @(posedge i_clk) begin
    model_dv <= 1'b0;
    if (ram_wr_dv) ram_mem[ram_addr] <= ram_wr_data;
    if (ram_rd_en) begin
      model_dv   <= 1'b1;
      model_data <= ram_mem[ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] ref_mem [256];
  int total = 0;
  int bad   = 0;
  int n_rsp = 0;
  logic last_acc = 1'b0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: record the handshakes about to happen at the next rising
  // edge, check any response against the queue, then return at the falling
  // edge so the caller can drive the next cycle.
  task automatic cycle();
    logic [WIDTH-1:0] e;
    #1;
    last_acc = bus.i_req_valid && bus.o_req_ready;
    if (last_acc) begin
      if (bus.i_req_we) ref_mem[bus.i_req_addr] = bus.i_req_wdata;
      else              exp_q.push_back(ref_mem[bus.i_req_addr]);
    end
    if (bus.o_rsp_valid && bus.i_rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) chk(32'(bus.o_rsp_valid), 32'd0, "rsp_unexpected");
      else begin
        e = exp_q.pop_front();
        chk(32'(bus.o_rsp_data), 32'(e), "rsp_data");
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_addr  = a;
    bus.i_req_wdata = d;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) chk(32'(bus.o_req_ready), 32'd1, "send_timeout");
  endtask

  task automatic drain();
    bus.i_req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    chk(32'(exp_q.size()), 32'd0, "drain_empty");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int base;
    i_rst_n         = 1'b0;
    inject_dv       = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_rsp_ready = 1'b0;

    // Reset and ready timing
    repeat (3) @(negedge i_clk);
    chk(32'(bus.o_req_ready), 32'd0, "rst_ready");
    chk(32'(bus.o_rsp_valid), 32'd0, "rst_rsp_valid");
    chk(32'(err), 32'd0, "rst_err");
    i_rst_n = 1'b1;
    #1;
    chk(32'(bus.o_req_ready), 32'd0, "ready_before_edge");
    @(negedge i_clk);
    chk(32'(bus.o_req_ready), 32'd1, "ready_after_release");

    // Write 0xBEEF to 0x12, then read it back
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_addr  = 8'h12;
    bus.i_req_wdata = 16'hBEEF;
    #1;
    chk(32'(ram_wr_dv), 32'd1, "wr_dv");
    chk(32'(ram_rd_en), 32'd0, "wr_no_rd_en");
    chk(32'(ram_addr), 32'h12, "wr_addr");
    chk(32'(ram_wr_data), 32'hBEEF, "wr_data");
    cycle();
    bus.i_req_valid = 1'b0;
    #1;
    chk(32'(ram_wr_dv), 32'd0, "wr_dv_single");

    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b0;
    #1;
    chk(32'(ram_rd_en), 32'd1, "rd_en");
    chk(32'(ram_wr_dv), 32'd0, "rd_no_wr_dv");
    cycle();
    chk(32'(last_acc), 32'd1, "rd_accept");
    bus.i_req_valid = 1'b0;
    chk(32'(bus.o_rsp_valid), 32'd0, "rd_lat1");
    cycle();
    chk(32'(bus.o_rsp_valid), 32'd1, "rd_lat2");
    chk(32'(bus.o_rsp_data), 32'hBEEF, "rd_lat2_data");
    bus.i_rsp_ready = 1'b1;
    cycle();
    chk(32'(bus.o_rsp_valid), 32'd0, "rd_popped");

    // Streaming: preload 0..7, then back-to-back reads
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), WIDTH'(16'h100 + i));
    bus.i_req_valid = 1'b0;
    cycle();
    chk(32'(bus.o_req_ready), 32'd1, "stream_ready");
    base = n_rsp;
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0);
    drain();
    chk(32'(n_rsp - base), 32'd8, "stream_count");

    // Backpressure: only two reads fit while responses are held
    bus.i_rsp_ready = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b0;
    idx  = 0;
    base = n_rsp;
    for (int k = 0; k < 6; k++) begin
      bus.i_req_addr = AW'(idx);
      cycle();
      if (last_acc) idx++;
    end
    chk(32'(idx), 32'd2, "bp_accepted");
    chk(32'(bus.o_req_ready), 32'd0, "bp_ready_low");
    chk(32'(bus.o_rsp_valid), 32'd1, "bp_rsp_valid");
    bus.i_rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (idx >= 4) break;
      bus.i_req_addr = AW'(idx);
      cycle();
      if (last_acc) idx++;
    end
    chk(32'(idx), 32'd4, "bp_all_accepted");
    drain();
    chk(32'(n_rsp - base), 32'd4, "bp_rsp_count");

    // Push and pop in the same cycle with one entry buffered
    bus.i_rsp_ready = 1'b0;
    send(1'b0, 8'd5, '0);
    send(1'b0, 8'd6, '0);
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    cycle();
    chk(32'(bus.o_rsp_valid), 32'd1, "pp_valid");
    chk(32'(bus.o_rsp_data), 32'h106, "pp_head");
    chk(32'(bus.o_req_ready), 32'd1, "pp_ready");
    cycle();
    chk(32'(bus.o_rsp_valid), 32'd0, "pp_count1");

    // Spurious read data: sticky error, nothing buffered
    inject_dv = 1'b1;
    cycle();
    inject_dv = 1'b0;
    chk(32'(err), 32'd1, "err_set");
    chk(32'(bus.o_rsp_valid), 32'd0, "err_no_push");
    repeat (3) cycle();
    chk(32'(err), 32'd1, "err_sticky");
    chk(32'(bus.o_rsp_valid), 32'd0, "err_still_empty");

    // Reset with a read in flight: nothing comes out afterwards
    bus.i_rsp_ready = 1'b0;
    send(1'b0, 8'd7, '0);
    bus.i_req_valid = 1'b0;
    i_rst_n = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    chk(32'(err), 32'd0, "err_cleared");
    chk(32'(bus.o_req_ready), 32'd0, "midrst_ready");
    chk(32'(bus.o_rsp_valid), 32'd0, "midrst_rsp_valid");
    i_rst_n = 1'b1;
    bus.i_rsp_ready = 1'b1;
    repeat (3) cycle();
    chk(32'(bus.o_rsp_valid), 32'd0, "post_rst_no_rsp");
    chk(32'(err), 32'd0, "post_rst_err");
    chk(32'(bus.o_req_ready), 32'd1, "post_rst_ready");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
